// File: rtl/stage_pkg.sv
// Shared types and the rounding/clamp helper used by the convolution output stages.
package stage_pkg;

    localparam int PIX_BITS = 8;

    typedef logic [PIX_BITS-1:0] pix_t;

    typedef struct packed {
        pix_t pix;
        logic eol;
        logic eof;
    } pix_word_t;

    // Adds half an LSB, then arithmetic-shifts right and clamps the result to [0, 2^pix_w-1].
    // 34-bit internals hold any 32-bit sum plus the rounding term without overflow.
    function automatic logic [31:0] sat_round(input logic signed [31:0] sum,
                                              input int shift,
                                              input int pix_w);
        logic signed [33:0] r;
        logic signed [33:0] s;
        logic signed [33:0] max_v;
        r = {{2{sum[31]}}, sum};
        if (shift > 0) begin
            r = r + (34'sd1 <<< (shift - 1));
        end
        s     = r >>> shift;
        max_v = (34'sd1 <<< pix_w) - 34'sd1;
        if (s < 0) begin
            return 32'd0;
        end else if (s > max_v) begin
            return max_v[31:0];
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/stage4_fifo.sv
// Show-ahead FIFO: the head entry is presented on rd_data whenever the FIFO is non-empty.
module stage4_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = rd_en && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/stage4_output.sv
// Output stage: round/clamp each stage3 sum, tag line/frame ends, and buffer pixels toward the writer.
// Upstream cannot stall, so a full FIFO drops pixels and raises a sticky overflow flag.
module stage4_output
    import stage_pkg::*;
#(
    parameter int WIDTH = 14,
    parameter int PIX_W = 8,
    parameter int SHIFT = 4,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH:0]   sum_in,
    input  logic                    sum_valid,
    output logic [PIX_W-1:0]        pix_out,
    output logic                    pix_eol,
    output logic                    pix_eof,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic                    overflow,
    output logic                    frame_done,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H + 1);
    localparam int WW = PIX_W + 2;

    logic [1:0]    state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          proc_valid;
    logic [WW-1:0] proc_word;
    logic [WW-1:0] head;
    logic [31:0]   sat_val;
    logic          accept;
    logic          at_eol;
    logic          at_eof;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          drop;
    logic          done_evt;

    assign accept   = (state == ST_RUN) && sum_valid && !start;
    assign at_eol   = (col == CW'(IMG_W - 1));
    assign at_eof   = at_eol && (row == RW'(IMG_H - 1));
    assign sat_val  = sat_round(32'(sum_in), SHIFT, PIX_W);

    assign pix_valid = !fifo_empty;
    assign pop       = pix_valid && pix_ready;
    assign drop      = proc_valid && fifo_full && !pop;
    // The frame ends when the eof pixel leaves the FIFO, or when it is lost to overflow.
    assign done_evt  = (pop && head[0]) || (drop && proc_word[0]);

    assign pix_out   = head[WW-1:2];
    assign pix_eol   = head[1];
    assign pix_eof   = head[0];
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            col        <= '0;
            row        <= '0;
            proc_valid <= 1'b0;
            proc_word  <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else if (start) begin
            state      <= ST_RUN;
            col        <= '0;
            row        <= '0;
            proc_valid <= 1'b0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= done_evt;
            proc_valid <= accept;
            if (drop) overflow <= 1'b1;
            if (accept) begin
                proc_word <= {sat_val[PIX_W-1:0], at_eol, at_eof};
                if (at_eof) begin
                    col   <= '0;
                    row   <= '0;
                    state <= ST_DRAIN;
                end else if (at_eol) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (done_evt) state <= ST_IDLE;
        end
    end

    stage4_fifo #(
        .W     (WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (start),
        .wr_en   (proc_valid),
        .wr_data (proc_word),
        .rd_en   (pix_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_stage4_output.sv
// Bench for stage4_output with a small 4x2 frame so line/frame tags and overflow are reachable quickly.
module tb_stage4_output;

  localparam int WIDTH = 14;
  localparam int PIX_W = 8;
  localparam int SHIFT = 4;
  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic signed [WIDTH:0] sum_in;
  logic                  sum_valid;
  logic [PIX_W-1:0]      pix_out;
  logic                  pix_eol;
  logic                  pix_eof;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  overflow;
  logic                  frame_done;
  logic                  busy;
  logic [1:0]            dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int b_col = 0;
  int b_row = 0;
  logic [PIX_W+1:0] exp_q[$];
  logic [PIX_W+1:0] mon_exp;

  typedef struct {
    int         sum;
    logic [7:0] pix;
  } vec_t;

  vec_t t1[5];

  stage4_output #(
    .WIDTH (WIDTH), .PIX_W (PIX_W), .SHIFT (SHIFT),
    .IMG_W (IMG_W), .IMG_H (IMG_H), .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sum_in     (sum_in),
    .sum_valid  (sum_valid),
    .pix_out    (pix_out),
    .pix_eol    (pix_eol),
    .pix_eof    (pix_eof),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .overflow   (overflow),
    .frame_done (frame_done),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one sum for one cycle; the bench tracks frame geometry to predict eol/eof.
  task automatic send_sum(input int s, input logic [7:0] p, input bit push);
    logic e;
    logic f;
    e = (b_col == IMG_W - 1);
    f = e && (b_row == IMG_H - 1);
    if (push) exp_q.push_back({p, e, f});
    if (e) begin
      b_col = 0;
      b_row = f ? 0 : b_row + 1;
    end else begin
      b_col++;
    end
    sum_in    = (WIDTH+1)'(s);
    sum_valid = 1'b1;
    @(posedge clk);
    #1;
    sum_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    b_col = 0;
    b_row = 0;
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard: every pop is compared against the oldest expected word
  always @(negedge clk) begin
    if (!rst && pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pixel: got %0d expected none", pix_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pixel_word", 32'({pix_out, pix_eol, pix_eof}), 32'(mon_exp));
      end
    end
  end

  initial begin
    bit seen;

    t1[0] = '{100,   8'd6};
    t1[1] = '{8,     8'd1};
    t1[2] = '{7,     8'd0};
    t1[3] = '{-50,   8'd0};
    t1[4] = '{16383, 8'd255};

    rst = 1'b1; start = 1'b0; sum_valid = 1'b0; sum_in = '0; pix_ready = 1'b0;
    #2;
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_out", pix_out, 0);
    check("rst_eol_eof", {pix_eol, pix_eof}, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // single sums: rounding/clamp and 2-cycle latency
    do_start();
    check("start_busy", busy, 1);
    pix_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_sum(t1[i].sum, t1[i].pix, 1'b1);
      @(negedge clk);
      check("latency_k", pix_valid, 0);
      @(negedge clk);
      check("latency_k1", pix_valid, 1);
      idle(2);
    end
    check("t1_drained", exp_q.size(), 0);

    // full frame: tags, frame_done, busy fall
    do_start();
    for (int i = 0; i < 8; i++) send_sum(160, 8'd10, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (pix_valid && pix_eof) seen = 1'b1;
    end
    check("eof_seen", seen, 1);
    if (seen) begin
      check("done_before", frame_done, 0);
      @(negedge clk);
      check("frame_done_pulse", frame_done, 1);
      check("busy_fall", busy, 0);
      @(negedge clk);
      check("frame_done_single", frame_done, 0);
    end
    #1;
    send_sum(160, 8'd10, 1'b0);
    idle(3);
    check("after_eof_ignored", pix_valid, 0);
    check("t2_drained", exp_q.size(), 0);

    // overflow: ready low, 6 sums into a 4-deep FIFO
    do_start();
    pix_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send_sum(16 * i, 8'(i), i <= 4);
    idle(2);
    check("ovf_set", overflow, 1);
    check("ovf_head", pix_out, 1);
    pix_ready = 1'b1;
    idle(8);
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_empty", pix_valid, 0);
    check("ovf_sticky", overflow, 1);

    // full FIFO with simultaneous write and pop: no drop
    do_start();
    pix_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_sum(16 * i, 8'(i), 1'b1);
    pix_ready = 1'b1;
    idle(8);
    check("full_wr_pop_no_ovf", overflow, 0);
    check("full_wr_pop_drained", exp_q.size(), 0);

    // reset mid-frame
    do_start();
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_sum(160, 8'd10, 1'b1);
    idle(1);
    rst = 1'b1;
    #1;
    check("midrst_pix_valid", pix_valid, 0);
    check("midrst_pix_out", pix_out, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    idle(1);
    rst = 1'b0;
    pix_ready = 1'b1;
    for (int i = 0; i < 2; i++) send_sum(160, 8'd10, 1'b0);
    idle(3);
    check("idle_sums_ignored", pix_valid, 0);
    do_start();
    for (int i = 0; i < 4; i++) send_sum(160, 8'(10), 1'b1);
    idle(4);
    check("restart_drained", exp_q.size(), 0);

    // start together with sum_valid: sum discarded, FIFO flushed, overflow cleared
    do_start();
    pix_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send_sum(16 * i, 8'(i), 1'b0);
    idle(1);
    check("pre_start_ovf", overflow, 1);
    start = 1'b1; sum_valid = 1'b1; sum_in = (WIDTH+1)'(800);
    @(posedge clk);
    #1;
    start = 1'b0; sum_valid = 1'b0;
    b_col = 0; b_row = 0;
    exp_q.delete();
    @(negedge clk);
    check("start_flush_valid", pix_valid, 0);
    check("start_clr_ovf", overflow, 0);
    check("start_busy2", busy, 1);
    idle(3);
    check("start_sum_discarded", pix_valid, 0);
    pix_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_sum(32, 8'd2, 1'b1);
    idle(4);
    check("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
